sram_port_master: RTL and testbench

- Initiator for the 64x128 single-port SRAM macro model. Converts a 64-bit valid/ready request channel from an LSU or cache into SRAM port cycles.
- Expands byte strobes into the SRAM's active-low per-bit write mask and registers the one-cycle read data into a held response.
- Clears the whole array to zero after every reset before accepting traffic.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_mask_gen.sv | 20 ++
 rtl/sram_port_master.sv | 121 ++++++++++++
 tb/tb_sram_port_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the 64x128 SRAM port master.
package sram_pkg;

  localparam int SRAM_ROWS = 64;
  localparam int SRAM_W    = 128;
  localparam int SRAM_AW   = 6;
  localparam int REQ_W     = 64;
  localparam int STRB_W    = REQ_W / 8;
  localparam int ADDR_W    = 10;

  // FSM encoding
  localparam logic [1:0] INIT    = 2'd0;
  localparam logic [1:0] IDLE    = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  // Pattern driven whenever the port has nothing to do: a harmless read of row 0
  localparam logic [SRAM_AW-1:0] IDLE_ADDR  = '0;
  localparam logic               IDLE_WEN   = 1'b1;
  localparam logic [SRAM_W-1:0]  IDLE_WMASK = '1;
  localparam logic [SRAM_W-1:0]  IDLE_WDATA = '0;

endpackage

// File: rtl/sram_mask_gen.sv
// Byte strobes -> active-low per-bit SRAM write mask for the selected half.
module sram_mask_gen
  import sram_pkg::*;
(
  input  logic [STRB_W-1:0] wstrb,
  input  logic              half,
  output logic [SRAM_W-1:0] wmask
);

  logic [REQ_W-1:0] half_mask;

  // An enabled byte clears its 8 mask bits so the SRAM writes them
  for (genvar i = 0; i < STRB_W; i++) begin : g_byte
    assign half_mask[8*i +: 8] = {8{~wstrb[i]}};
  end

  // The unselected half always keeps its old contents
  assign wmask = half ? {half_mask, {REQ_W{1'b1}}} : {{REQ_W{1'b1}}, half_mask};

endmodule

// File: rtl/sram_port_master.sv
// Valid/ready 64-bit request channel -> 64x128 single-port SRAM cycles.
// Clears the array after reset, then serves one request at a time.
module sram_port_master
  import sram_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [REQ_W-1:0]   req_wdata,
  input  logic [STRB_W-1:0]  req_wstrb,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [REQ_W-1:0]   resp_rdata,
  output logic               resp_write,
  output logic               init_done,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_wen,
  output logic [SRAM_W-1:0]  sram_wmask,
  output logic [SRAM_W-1:0]  sram_wdata,
  input  logic [SRAM_W-1:0]  sram_rdata
);

  logic [1:0]         state;
  logic [SRAM_AW-1:0] cnt;
  logic               half_q;
  logic               accept;
  logic [SRAM_W-1:0]  gen_mask;

  // Byte-within-word bits never reach the SRAM
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[2:0];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  sram_mask_gen u_mask (
    .wstrb (req_wstrb),
    .half  (req_addr[3]),
    .wmask (gen_mask)
  );

  // SRAM port: clear writes in INIT, request drive on accept, idle read otherwise
  always_comb begin
    sram_addr  = IDLE_ADDR;
    sram_wen   = IDLE_WEN;
    sram_wmask = IDLE_WMASK;
    sram_wdata = IDLE_WDATA;
    case (state)
      INIT: begin
        sram_wen   = 1'b0;
        sram_addr  = cnt;
        sram_wmask = '0;
      end
      IDLE: begin
        if (accept) begin
          sram_addr = req_addr[9:4];
          if (req_write) begin
            sram_wen   = 1'b0;
            sram_wdata = {req_wdata, req_wdata};
            sram_wmask = gen_mask;
          end
        end
      end
      default: ;
    endcase
  end

  // FSM, clear counter and held response
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      cnt        <= '0;
      half_q     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_write <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == SRAM_AW'(SRAM_ROWS - 1)) state <= IDLE;
        end
        IDLE: begin
          if (accept) begin
            if (req_write) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_write <= 1'b1;
            end else begin
              state  <= RD_WAIT;
              half_q <= req_addr[3];
            end
          end
        end
        RD_WAIT: begin
          resp_rdata <= half_q ? sram_rdata[SRAM_W-1:REQ_W] : sram_rdata[REQ_W-1:0];
          resp_write <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        default: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

  // Sticky clear-complete flag, rises the cycle after the last row is written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                              init_done <= 1'b0;
    else if (state == INIT && cnt == SRAM_AW'(SRAM_ROWS - 1)) init_done <= 1'b1;
  end

endmodule

// File: tb/tb_sram_port_master.sv
// Self-checking bench: SRAM behavioural model, byte-addressed reference memory,
// directed vector table, hand sequences for stall/reset, random traffic.
module tb_sram_port_master;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_write;
  logic [9:0]   req_addr;
  logic [63:0]  req_wdata;
  logic [7:0]   req_wstrb;
  logic         resp_valid, resp_ready, resp_write, init_done;
  logic [63:0]  resp_rdata;
  logic [5:0]   sram_addr;
  logic         sram_wen;
  logic [127:0] sram_wmask, sram_wdata, sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sram_port_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_write(resp_write), .init_done(init_done),
    .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // SRAM macro model, starts with random contents so the clear is observable
  logic [127:0] mem [0:63];
  bit seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int r = 0; r < 64; r++) mem[r] <= {$urandom, $urandom, $urandom, $urandom};
      seeded     <= 1'b1;
      sram_rdata <= '0;
    end else if (!sram_wen) begin
      mem[sram_addr] <= (mem[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
      sram_rdata     <= '0;
    end else begin
      sram_rdata <= mem[sram_addr];
    end
  end

  // Reference: flat byte memory indexed by the request byte address
  logic [7:0] ref_mem [0:1023];

  task automatic ref_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic ref_write(input logic [9:0] a, input logic [63:0] d, input logic [7:0] s);
    int base = int'(a) & ~7;
    for (int i = 0; i < 8; i++) if (s[i]) ref_mem[base + i] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] ref_read(input logic [9:0] a);
    logic [63:0] r;
    int base = int'(a) & ~7;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[base + i];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at the negedge right after reset release
  task automatic init_check();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (sram_wen !== 1'b0 || sram_addr !== 6'(i) || init_done !== 1'b0 ||
          req_ready !== 1'b0 || resp_valid !== 1'b0 || sram_wmask !== '0 || sram_wdata !== '0)
        bad++;
      @(negedge clock); #1;
    end
    check("init_seq_bad_cycles", bad, 0);
    check("init_done_wen_ready", {init_done, sram_wen, req_ready}, 3'b111);
  endtask

  // One full transaction; entered and left shortly after a negedge
  task automatic do_req(input bit wr, input logic [9:0] a, input logic [63:0] d,
                        input logic [7:0] s, input int hold,
                        output logic [63:0] rd, output logic rw);
    int waited = 0;
    int lat;
    int bad = 0;
    logic [127:0] em, ed;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    #1;
    while (!req_ready && waited < 20) begin @(negedge clock); #1; waited++; end
    if (!req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
      req_valid = 1'b0; rd = '0; rw = 1'b0;
      return;
    end
    for (int b = 0; b < 16; b++)
      em[8*b +: 8] = (wr && (b / 8) == int'(a[3]) && s[b % 8]) ? 8'h00 : 8'hFF;
    ed = wr ? {d, d} : 128'h0;
    check("port_addr_wen", {sram_addr, sram_wen}, {a[9:4], ~wr});
    check("port_wmask", sram_wmask, em);
    check("port_wdata", sram_wdata, ed);
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0; #1;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(negedge clock); #1; lat++; end
    check("resp_latency", lat, wr ? 1 : 2);
    rd = resp_rdata; rw = resp_write;
    check("resp_write", rw, wr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_write !== rw || req_ready !== 1'b0) bad++;
    end
    if (hold > 0) check("resp_hold_bad_cycles", bad, 0);
    resp_ready = 1'b1;
    @(negedge clock); #1;
    resp_ready = 1'b0;
    check("ready_after_hs", {req_ready, resp_valid}, 2'b10);
  endtask

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        rw;
    int          bad;

    vecs[0]  = '{0, 10'h3F8, 64'h0, 8'h00, 64'h0};
    vecs[1]  = '{1, 10'h018, 64'h1122334455667788, 8'hFF, 64'h0};
    vecs[2]  = '{0, 10'h018, 64'h0, 8'h00, 64'h1122334455667788};
    vecs[3]  = '{0, 10'h010, 64'h0, 8'h00, 64'h0};
    vecs[4]  = '{1, 10'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
    vecs[5]  = '{1, 10'h020, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'h0};
    vecs[6]  = '{0, 10'h020, 64'h0, 8'h00, 64'hFFFF_FFFF_BBBB_BBBB};
    vecs[7]  = '{1, 10'h000, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
    vecs[8]  = '{1, 10'h3F8, 64'hFEDCBA9876543210, 8'hFF, 64'h0};
    vecs[9]  = '{0, 10'h000, 64'h0, 8'h00, 64'h0123456789ABCDEF};
    vecs[10] = '{0, 10'h3FF, 64'h0, 8'h00, 64'hFEDCBA9876543210};
    vecs[11] = '{1, 10'h028, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 64'h0};
    vecs[12] = '{0, 10'h028, 64'h0, 8'h00, 64'h0};

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    ref_clear();

    repeat (3) @(negedge clock);
    #1;
    check("reset_state", {resp_valid, init_done, req_ready, resp_write, resp_rdata},
          {4'b0000, 64'h0});
    @(negedge clock);
    reset = 1'b1; #1;
    init_check();

    // Directed vectors
    for (int v = 0; v < 13; v++) begin
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, 0, rd, rw);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
      check($sformatf("vec%0d_ref", v), rd, vecs[v].wr ? 64'h0 : ref_read(vecs[v].addr));
      if (vecs[v].wr) ref_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb);
    end

    // Response back-pressure for 5 cycles
    do_req(1'b0, 10'h018, 64'h0, 8'h00, 5, rd, rw);
    check("stall_rdata", rd, 64'h1122334455667788);

    // Reset in RD_WAIT drops the read and re-clears the array
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h018; #1;
    @(posedge clock);
    @(negedge clock); req_valid = 1'b0; reset = 1'b0;
    bad = 0;
    repeat (3) begin #1; if (resp_valid !== 1'b0) bad++; @(negedge clock); end
    reset = 1'b1; #1;
    ref_clear();
    init_check();
    check("dropped_resp_cycles", bad, 0);
    do_req(1'b0, 10'h018, 64'h0, 8'h00, 0, rd, rw);
    check("after_reset_rdata", rd, 64'h0);

    // Random traffic, concentrated on a few rows for read-after-write hits
    for (int n = 0; n < 60; n++) begin
      bit          wr = 1'($urandom);
      logic [9:0]  a  = 10'($urandom);
      logic [63:0] d  = {$urandom, $urandom};
      logic [7:0]  s  = 8'($urandom);
      if ($urandom_range(0, 1) == 0) a[9:4] = 6'($urandom_range(0, 3));
      do_req(wr, a, d, s, $urandom_range(0, 2), rd, rw);
      check("rand_rdata", rd, wr ? 64'h0 : ref_read(a));
      if (wr) ref_write(a, d, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
